// File: rtl/cclaa_x4bit_reg_pkg.sv
// Shared constants for the cascaded 4-bit carry look-ahead adder slice.
package cclaa_x4bit_reg_pkg;

  localparam int unsigned GRP_W = 4;

endpackage

// File: rtl/cclaa_x4bit_reg_cla4.sv
// One 4-bit carry look-ahead group: every internal carry is a flat sum of
// products of generate/propagate terms and the group carry-in.
module cla4_group
  import cclaa_x4bit_reg_pkg::*;
(
  input  logic             ci,
  input  logic [GRP_W-1:0] a,
  input  logic [GRP_W-1:0] b,
  output logic [GRP_W-1:0] s,
  output logic             co
);

  logic [GRP_W-1:0] p;
  logic [GRP_W-1:0] g;
  logic [GRP_W:0]   c;

  always_comb begin
    p = a ^ b;
    g = a & b;

    c[0] = ci;
    c[1] = g[0] | (p[0] & ci);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & ci);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
         | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & ci);

    s  = p ^ c[GRP_W-1:0];
    co = c[GRP_W];
  end

endmodule

// File: rtl/cclaa_x4bit_reg.sv
// W-bit adder from cascaded 4-bit look-ahead groups; {co,sum} registered
// once, giving one cycle of latency and a new operand pair every cycle.
module cclaa_x4bit_reg
  import cclaa_x4bit_reg_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ci,
  input  logic [W-1:0] ain,
  input  logic [W-1:0] bin,
  output logic [W-1:0] sum,
  output logic         co
);

  localparam int unsigned NG = W / GRP_W;

  if ((W % GRP_W) != 0 || W < GRP_W) begin : g_bad_width
    $error("cclaa_x4bit_reg: W=%0d must be a multiple of 4 and >= 4", W);
  end

  logic [NG:0]  carry;
  logic [W-1:0] sum_c;

  assign carry[0] = ci;

  for (genvar k = 0; k < NG; k++) begin : g_grp
    cla4_group u_grp (
      .ci (carry[k]),
      .a  (ain[GRP_W*k +: GRP_W]),
      .b  (bin[GRP_W*k +: GRP_W]),
      .s  (sum_c[GRP_W*k +: GRP_W]),
      .co (carry[k+1])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum <= '0;
      co  <= 1'b0;
    end else begin
      sum <= sum_c;
      co  <= carry[NG];
    end
  end

endmodule

// File: tb/tb_cclaa_x4bit_reg.sv
// Directed and random checks of the registered look-ahead adder at W=4, 8, 32.
module tb_cclaa_x4bit_reg;

  logic clk = 1'b0;
  logic rst_n;

  logic        ci4,  co4;
  logic [3:0]  a4, b4, s4;
  logic        ci8,  co8;
  logic [7:0]  a8, b8, s8;
  logic        ci32, co32;
  logic [31:0] a32, b32, s32;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;

  cclaa_x4bit_reg #(.W(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .ci(ci4), .ain(a4), .bin(b4), .sum(s4), .co(co4)
  );
  cclaa_x4bit_reg #(.W(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .ci(ci8), .ain(a8), .bin(b8), .sum(s8), .co(co8)
  );
  cclaa_x4bit_reg #(.W(32)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .ci(ci32), .ain(a32), .bin(b32), .sum(s32), .co(co32)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive8(input logic [7:0] a, input logic [7:0] b, input logic c);
    a8  = a;
    b8  = b;
    ci8 = c;
  endtask

  // Directed W=8 vectors: {a, b, ci, expected {co,sum}}
  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       c;
    logic [8:0] exp;
    string      tag;
  } vec_t;

  vec_t vecs[4] = '{
    '{8'hFF, 8'h00, 1'b1, 9'h100, "carry_through_both"},
    '{8'h0F, 8'h01, 1'b0, 9'h010, "group_boundary"},
    '{8'hFF, 8'hFF, 1'b1, 9'h1FF, "all_ones_ci"},
    '{8'h00, 8'h00, 1'b0, 9'h000, "all_zero"}
  };

  initial begin
    logic [4:0]  e4;
    logic [8:0]  e8;
    logic [32:0] e32;

    rst_n = 1'b0;
    drive8(8'hFF, 8'hFF, 1'b1);
    a4 = 4'hF; b4 = 4'hF; ci4 = 1'b1;
    a32 = '1;  b32 = '1;  ci32 = 1'b1;

    // Reset held with clock running and busy inputs
    #2;
    check("rst_between_edges", 64'({co8, s8}), 64'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_held8", 64'({co8, s8}), 64'h0);
      check("rst_held4", 64'({co4, s4}), 64'h0);
      check("rst_held32", 64'({co32, s32}), 64'h0);
    end

    // Release mid-cycle: stays 0 until the next edge, which captures 0xFF+0xFF+1
    #2;
    rst_n = 1'b1;
    #1;
    check("release_no_edge", 64'({co8, s8}), 64'h0);
    tick();
    check("first_capture", 64'({co8, s8}), 64'h1FF);

    // Asynchronous clear between edges
    #2;
    rst_n = 1'b0;
    #1;
    check("async_clear", 64'({co8, s8}), 64'h0);
    tick();
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      drive8(vecs[i].a, vecs[i].b, vecs[i].c);
      tick();
      check(vecs[i].tag, 64'({co8, s8}), 64'(vecs[i].exp));
    end

    // Back-to-back operands on consecutive edges
    drive8(8'h12, 8'h34, 1'b0);
    tick();
    check("b2b_first", 64'({co8, s8}), 64'h046);
    drive8(8'h80, 8'h80, 1'b1);
    tick();
    check("b2b_second", 64'({co8, s8}), 64'h101);

    // Random scoreboard across all three widths, with a reset pulse mid-run
    for (int i = 0; i < 1000; i++) begin
      a4  = 4'($urandom);  b4  = 4'($urandom);  ci4  = 1'($urandom);
      a8  = 8'($urandom);  b8  = 8'($urandom);  ci8  = 1'($urandom);
      a32 = $urandom;      b32 = $urandom;      ci32 = 1'($urandom);
      e4  = 5'(a4)  + 5'(b4)  + 5'(ci4);
      e8  = 9'(a8)  + 9'(b8)  + 9'(ci8);
      e32 = 33'(a32) + 33'(b32) + 33'(ci32);
      tick();
      check("rand_w4",  64'({co4, s4}),   64'(e4));
      check("rand_w8",  64'({co8, s8}),   64'(e8));
      check("rand_w32", 64'({co32, s32}), 64'(e32));
      if (i == 500) begin
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_w4",  64'({co4, s4}),   64'h0);
        check("mid_rst_w8",  64'({co8, s8}),   64'h0);
        check("mid_rst_w32", 64'({co32, s32}), 64'h0);
        tick();
        check("mid_rst_hold", 64'({co32, s32}), 64'h0);
        rst_n = 1'b1;
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
